concat_packer: RTL
==================

Name: concat_packer

Overview:
- Parametrised, clocked successor to the fixed concatenation/replication assigns: packs a stream of WD-bit words into RATIO-word wide words.
- Word order is selectable; short groups are padded by replicating PAD.
- Valid/ready handshake on both sides, with a one-entry output register.
- Sits between narrow producers and wide consumers, e.g. gate-array result buses.

Parameters:
- WD, 4, input word width in bits (>=1).
- RATIO, 3, input words per output word (>=1).
- MSB_FIRST, 1, 1 = first word goes to the most significant slot (same order as {w0,w1,w2}); 0 = first word goes to the least significant slot.
- PAD, 0, WD-bit value written into unfilled slots of a short group.
- CW, $clog2(RATIO+1), width of out_count (derived; not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  in_data/in_last valid.
- in_ready  output  1  packer accepts a word this cycle.
- in_data  input  WD  input word.
- in_last  input  1  final word of a frame; closes the group early.
- out_valid  output  1  out_* holds a group.
- out_ready  input  1  consumer takes the group.
- out_data  output  WD*RATIO  packed word.
- out_count  output  CW  number of real words in out_data (1..RATIO).
- out_last  output  1  group closed by in_last.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, out_data=0, out_count=0, out_last=0.
  - Fill counter cnt=0; accumulator = {RATIO{PAD}}.
  - in_ready is 1 once out_valid=0.
  - Any partial group is discarded; no output results from it.
- Handshakes:
  - Accept = in_valid & in_ready. Transfer out = out_valid & out_ready.
  - in_ready = !out_valid | out_ready (combinational; no path from in_valid or in_data).
- Slot k (0-based, k = cnt at accept):
  - MSB_FIRST=1: bits [WD*(RATIO-k)-1 : WD*(RATIO-1-k)].
  - MSB_FIRST=0: bits [WD*(k+1)-1 : WD*k].
- Accept with cnt < RATIO-1 and in_last=0: write in_data into slot cnt; cnt <= cnt+1. Outputs unchanged.
- Accept with cnt == RATIO-1 or in_last=1 (group close):
  - out_data <= accumulator with in_data merged into slot cnt.
  - out_count <= cnt+1; out_last <= in_last; out_valid <= 1.
  - cnt <= 0; accumulator <= {RATIO{PAD}}.
- Latency: the group appears on out_* the cycle after its closing word is accepted.
- Output hold: while out_valid=1 and out_ready=0, out_data, out_count and out_last are stable and in_ready=0.
- Transfer with no close in the same cycle: out_valid <= 0; out_data, out_count and out_last keep their values.
- Transfer and close in the same cycle: output register reloads and out_valid stays 1. This gives full input throughput with no bubble.
- in_last on the word that also fills slot RATIO-1: normal close, out_count=RATIO, out_last=1.
- RATIO=1: every accept closes. The block degenerates to a register slice with out_count=1.
- cnt wraps only through the close rule; it never reaches RATIO.
- in_data is ignored when no accept occurs.

Test Plan:
- Full group, WD=4, RATIO=3, MSB_FIRST=1, out_ready=1: accept A,B,C -> next cycle out_valid=1, out_data=12'hABC, out_count=3, out_last=0.
- Same stimulus with MSB_FIRST=0 -> out_data=12'hCBA.
- Short group: A, then B with in_last=1. PAD=0 -> 12'hAB0, out_count=2, out_last=1. PAD=4'hF -> 12'hABF.
- Backpressure: close group ABC with out_ready=0 for 5 cycles -> in_ready=0, out_data held at 12'hABC. Then out_ready=1 -> one transfer, in_ready=1.
- Reset mid-group: accept A,B, pulse rst, then C,D,E -> the only output is 12'hCDE, out_count=3; no output contains A or B.
- Streaming: words 1..9 with in_valid=1 and out_ready=1 throughout -> in_ready never drops; outputs 12'h123, 12'h456, 12'h789 at 3-cycle spacing.

Source files
------------

// File: rtl/concat_packer.sv
// Packs a stream of WD-bit words into RATIO-word output words behind a one-entry output register.
// A group closes on its RATIO-th word or on in_last; unfilled slots carry PAD.
module concat_packer #(
  parameter int unsigned          WD        = 4,
  parameter int unsigned          RATIO     = 3,
  parameter bit                   MSB_FIRST = 1'b1,
  parameter logic [WD-1:0]        PAD       = '0,
  parameter int unsigned          CW        = $clog2(RATIO + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WD-1:0]       in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WD*RATIO-1:0] out_data,
  output logic [CW-1:0]       out_count,
  output logic                out_last
);

  localparam logic [WD*RATIO-1:0] ACC_INIT = {RATIO{PAD}};
  localparam logic [CW-1:0]       CNT_LAST = CW'(RATIO - 1);

  logic [CW-1:0]       cnt;
  logic [WD*RATIO-1:0] acc;
  logic [WD*RATIO-1:0] merged;
  logic                accept;
  logic                close;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign close    = accept && (in_last || (cnt == CNT_LAST));

  // accumulator with the incoming word dropped into the slot selected by cnt
  always_comb begin
    merged = acc;
    for (int k = 0; k < int'(RATIO); k++) begin
      if (cnt == CW'(k)) begin
        if (MSB_FIRST)
          merged[WD*(int'(RATIO)-1-k) +: WD] = in_data;
        else
          merged[WD*k +: WD] = in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= ACC_INIT;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (accept) begin
        if (close) begin
          out_data  <= merged;
          out_count <= cnt + CW'(1);
          out_last  <= in_last;
          out_valid <= 1'b1;
          cnt       <= '0;
          acc       <= ACC_INIT;
        end else begin
          acc <= merged;
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule
